// File: rtl/mos6502_pkg.sv
// Shared definitions for the MOS 6502 core datapath blocks.
package mos6502_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FIXUP = 1'b1
  } pc_state_t;

  localparam int DEFAULT_BYTE_W = 8;

endpackage

// File: rtl/pc_byte_adder.sv
// One PC byte adder with carry in and carry out; reused for low-byte inc/branch and high-byte inc/fix-up.
module pc_byte_adder #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/program_counter_unit.sv
// 6502 program counter: increment with carry, byte loads, relative branch with a
// page-cross fix-up cycle, and registered enable-gated bus outputs.
module program_counter_unit
  import mos6502_pkg::*;
#(
  parameter int                  BYTE_W   = DEFAULT_BYTE_W,
  parameter logic [2*BYTE_W-1:0] RESET_PC = '0
) (
  input  logic                  phi2,
  input  logic                  rst,
  input  logic                  inc_en,
  input  logic                  load_lo_en,
  input  logic                  load_hi_en,
  input  logic [BYTE_W-1:0]     adl_in,
  input  logic [BYTE_W-1:0]     adh_in,
  input  logic                  branch_en,
  input  logic [BYTE_W-1:0]     offset_in,
  input  logic                  adl_out_en,
  input  logic                  adh_out_en,
  input  logic                  db_lo_en,
  input  logic                  db_hi_en,
  output logic [BYTE_W-1:0]     adl_out,
  output logic [BYTE_W-1:0]     adh_out,
  output logic [BYTE_W-1:0]     db_out,
  output logic [2*BYTE_W-1:0]   pc_out,
  output logic                  busy,
  output logic                  page_cross
);

  pc_state_t          state;
  logic               dir;
  logic [BYTE_W-1:0]  pc_lo, pc_hi;

  logic               load_cmd;
  logic               fixup;
  logic signed [BYTE_W-1:0] offset_s;
  logic [BYTE_W-1:0]  lo_b, lo_sum, hi_b, hi_sum;
  logic               lo_cin, lo_cout, hi_cin, hi_cout;
  logic               crossed;

  assign load_cmd = load_lo_en | load_hi_en;
  assign fixup    = (state == FIXUP);
  assign offset_s = offset_in;
  assign pc_out   = {pc_hi, pc_lo};

  // Low adder adds the offset for a branch, otherwise +1; high adder takes the
  // low carry for increments, or +1 / -1 (add all-ones) during fix-up.
  always_comb begin
    lo_b   = '0;
    lo_cin = 1'b1;
    if (branch_en && !load_cmd) begin
      lo_b   = offset_in;
      lo_cin = 1'b0;
    end
    hi_b   = (fixup && dir) ? '1 : '0;
    hi_cin = fixup ? ~dir : lo_cout;
  end

  pc_byte_adder #(.W(BYTE_W)) u_lo_add (
    .a    (pc_lo),
    .b    (lo_b),
    .cin  (lo_cin),
    .sum  (lo_sum),
    .cout (lo_cout)
  );

  pc_byte_adder #(.W(BYTE_W)) u_hi_add (
    .a    (pc_hi),
    .b    (hi_b),
    .cin  (hi_cin),
    .sum  (hi_sum),
    .cout (hi_cout)
  );

  // Forward branch crosses on carry out; backward branch crosses on no carry.
  assign crossed = (offset_s < 0) ? ~lo_cout : lo_cout;

  always_ff @(posedge phi2) begin
    if (rst) begin
      pc_lo      <= RESET_PC[BYTE_W-1:0];
      pc_hi      <= RESET_PC[2*BYTE_W-1:BYTE_W];
      adl_out    <= '0;
      adh_out    <= '0;
      db_out     <= '0;
      busy       <= 1'b0;
      page_cross <= 1'b0;
      dir        <= 1'b0;
      state      <= RUN;
    end else begin
      if (adl_out_en) adl_out <= pc_lo;
      if (adh_out_en) adh_out <= pc_hi;
      if (db_hi_en)      db_out <= pc_hi;
      else if (db_lo_en) db_out <= pc_lo;

      busy       <= 1'b0;
      page_cross <= 1'b0;

      case (state)
        RUN: begin
          if (load_cmd) begin
            if (load_lo_en) pc_lo <= adl_in;
            if (load_hi_en) pc_hi <= adh_in;
          end else if (branch_en) begin
            pc_lo <= lo_sum;
            if (crossed) begin
              dir        <= offset_in[BYTE_W-1];
              busy       <= 1'b1;
              page_cross <= 1'b1;
              state      <= FIXUP;
            end
          end else if (inc_en) begin
            pc_lo <= lo_sum;
            pc_hi <= hi_sum;
          end
        end
        FIXUP: begin
          pc_hi <= hi_sum;
          state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule
